// File: rtl/tankb_video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tankb_video_pkg
//  Description : Shared types and default raster timing for the Tank
//                Battalion video timing generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package tankb_video_pkg;

  // 9-bit raster coordinate, wide enough for counts up to 511
  typedef logic [8:0] vcoord_t;

  // Largest total a 9-bit coordinate counter can represent
  localparam int COORD_LIMIT = 512;

  // Default timing of the original board
  localparam int DEF_CLK_DIV      = 2;
  localparam int DEF_H_TOTAL      = 384;
  localparam int DEF_H_ACTIVE     = 256;
  localparam int DEF_H_SYNC_START = 304;
  localparam int DEF_H_SYNC_END   = 336;
  localparam int DEF_V_TOTAL      = 264;
  localparam int DEF_V_ACTIVE     = 224;
  localparam int DEF_V_SYNC_START = 248;
  localparam int DEF_V_SYNC_END   = 252;

  // Half-open window test [lo, hi); done in int so hi may equal 512
  function automatic logic in_window(input vcoord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tankb_modcnt.sv
`default_nettype none
// ============================================================================
//  Module      : tankb_modcnt
//  Description : Mod-N up counter with count enable and terminal-count
//                output (behaves like a cascaded 161 with its rco). The
//                next-state value is exposed so callers can register
//                decodes that stay coherent with the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tankb_modcnt
  import tankb_video_pkg::*;
#(
  parameter int N = DEF_H_TOTAL
) (
  input  logic    clk,
  input  logic    n_clr,
  input  logic    ce,
  output vcoord_t q,
  output vcoord_t nxt,
  output logic    tc
);

  localparam vcoord_t LAST = vcoord_t'(N - 1);

  // Terminal count is qualified by ce, so it can enable the next stage
  assign tc = ce && (q == LAST);

  // Next count: hold, increment, or wrap to zero after the last value
  always_comb begin
    nxt = q;
    if (ce) begin
      nxt = (q == LAST) ? '0 : q + 9'd1;
    end
  end

  // Count register with asynchronous clear
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tankb_video_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tankb_video_timing
//  Description : Raster timing generator. Divides the master clock into a
//                pixel clock-enable, runs the chained H/V counters, and
//                decodes sync, blank, the shifter load strobe and a frame
//                start pulse. All decodes are registered from the counters'
//                next values so they switch on the same edge as the counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tankb_video_timing
  import tankb_video_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
  input  logic       clk,
  input  logic       n_clr,
  input  logic       en,
  output logic       pix_ce,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       n_hsync,
  output logic       n_vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       n_load,
  output logic       frame_start
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (CLK_DIV < 1) begin : g_chk_div
    $error("tankb_video_timing: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > COORD_LIMIT) begin : g_chk_htot
    $error("tankb_video_timing: H_TOTAL exceeds 9-bit range");
  end
  if (V_TOTAL > COORD_LIMIT) begin : g_chk_vtot
    $error("tankb_video_timing: V_TOTAL exceeds 9-bit range");
  end
  if (!((H_ACTIVE < H_SYNC_START) && (H_SYNC_START < H_SYNC_END) &&
        (H_SYNC_END <= H_TOTAL))) begin : g_chk_hord
    $error("tankb_video_timing: horizontal timing out of order");
  end
  if (!((V_ACTIVE < V_SYNC_START) && (V_SYNC_START < V_SYNC_END) &&
        (V_SYNC_END <= V_TOTAL))) begin : g_chk_vord
    $error("tankb_video_timing: vertical timing out of order");
  end

  // --------------------------------------------------------------------------
  // Pixel divider
  // --------------------------------------------------------------------------
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // Divider phase and registered pixel enable; both freeze while en is low
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else if (en) begin
      pix_ce <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Chained horizontal / vertical counters
  // --------------------------------------------------------------------------
  logic    h_ce;
  logic    h_tc;
  logic    v_tc;
  vcoord_t h_q;
  vcoord_t v_q;
  vcoord_t h_nxt;
  vcoord_t v_nxt;

  // A high pix_ce captured before en dropped must not advance the raster
  assign h_ce = en && pix_ce;

  tankb_modcnt #(
    .N (H_TOTAL)
  ) u_hcnt (
    .clk   (clk),
    .n_clr (n_clr),
    .ce    (h_ce),
    .q     (h_q),
    .nxt   (h_nxt),
    .tc    (h_tc)
  );

  // Line counter steps on the same edge the pixel counter wraps
  tankb_modcnt #(
    .N (V_TOTAL)
  ) u_vcnt (
    .clk   (clk),
    .n_clr (n_clr),
    .ce    (h_tc),
    .q     (v_q),
    .nxt   (v_nxt),
    .tc    (v_tc)
  );

  assign hcnt = h_q;
  assign vcnt = v_q;

  // --------------------------------------------------------------------------
  // Registered decodes, computed from next counts so they align with hcnt/vcnt
  // --------------------------------------------------------------------------
  // Sync, blank, load strobe and frame start pulse
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      n_hsync     <= 1'b1;
      n_vsync     <= 1'b1;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      n_load      <= 1'b1;
      frame_start <= 1'b0;
    end else if (en) begin
      n_hsync     <= !in_window(h_nxt, H_SYNC_START, H_SYNC_END);
      n_vsync     <= !in_window(v_nxt, V_SYNC_START, V_SYNC_END);
      hblank      <= in_window(h_nxt, H_ACTIVE, COORD_LIMIT);
      vblank      <= in_window(v_nxt, V_ACTIVE, COORD_LIMIT);
      n_load      <= !(h_nxt[2:0] == 3'd7);
      // v_tc is only true on the edge where both counters wrap to zero
      frame_start <= v_tc;
    end
  end

endmodule
`default_nettype wire
